// File: rtl/otf_sd2tc_conv_if.sv
// rtl/otf_sd2tc_conv_if.sv - digit-in / result-out handshake bundle for the on-the-fly converter
interface otf_sd2tc_conv_if #(
    parameter int RADIX = 2,
    parameter int WIDTH = 32
);
    localparam int L = $clog2(RADIX);
    localparam int D = L + 1;
    localparam int W = WIDTH * L + 1;

    logic         abort;
    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] in_digit;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_value;
    logic         digit_err;

    modport master (
        output abort, in_valid, in_digit, out_ready,
        input  in_ready, out_valid, out_value, digit_err
    );

    modport slave (
        input  abort, in_valid, in_digit, out_ready,
        output in_ready, out_valid, out_value, digit_err
    );
endinterface

// File: rtl/otf_sd2tc_conv.sv
// rtl/otf_sd2tc_conv.sv - MSDF signed-digit to two's complement converter (Q/QM); optional OTF_DIGIT_CHECK_EN
module otf_sd2tc_conv #(
    parameter int RADIX = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    otf_sd2tc_conv_if.slave  bus
);
    localparam int L  = $clog2(RADIX);
    localparam int D  = L + 1;
    localparam int W  = WIDTH * L + 1;
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] count;
    logic [W-1:0]  q;
    logic [W-1:0]  qm;
    logic [W-1:0]  q_next;
    logic [W-1:0]  qm_next;
    logic [W-1:0]  value;
    logic          valid_r;
    logic [D-1:0]  digit;
    logic [L-1:0]  slot_m1;
    logic          accept;
    logic          neg;
    logic          pos;
    logic          last;

    assign accept = !bus.abort && bus.in_valid && (state == COLLECT);
    assign last   = (count == CW'(WIDTH - 1));

`ifdef OTF_DIGIT_CHECK_EN
    logic bad;
    logic err_r;

    // -RADIX is the one code outside -A..+A; it is folded onto -A
    assign bad = (bus.in_digit == {1'b1, {L{1'b0}}});

    // Digit cleanup: replace the unrepresentable code by -A
    always_comb begin
        digit = bus.in_digit;
        if (bad) digit = bus.in_digit + D'(1);
    end

    // Sticky illegal-digit flag, only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             err_r <= 1'b0;
        else if (accept && bad) err_r <= 1'b1;
    end

    assign bus.digit_err = err_r;
`else
    assign digit         = bus.in_digit;
    assign bus.digit_err = 1'b0;
`endif

    // New slot values: Q takes d mod RADIX, QM takes (d-1) mod RADIX;
    // the sign of d only selects which register is shifted in.
    always_comb begin
        neg     = digit[D-1];
        pos     = !digit[D-1] && (|digit);
        slot_m1 = digit[L-1:0] - L'(1);
        q_next  = {(neg ? qm[W-L-1:0] : q[W-L-1:0]), digit[L-1:0]};
        qm_next = {(pos ? q[W-L-1:0] : qm[W-L-1:0]), slot_m1};
    end

    // Conversion registers, digit counter and result hold state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            count   <= '0;
            q       <= '0;
            qm      <= '1;
            value   <= '0;
            valid_r <= 1'b0;
        end else if (bus.abort) begin
            state   <= COLLECT;
            count   <= '0;
            q       <= '0;
            qm      <= '1;
            valid_r <= 1'b0;
        end else if (accept) begin
            if (last) begin
                value   <= q_next;
                valid_r <= 1'b1;
                state   <= HOLD;
                count   <= '0;
                q       <= '0;
                qm      <= '1;
            end else begin
                q     <= q_next;
                qm    <= qm_next;
                count <= count + CW'(1);
            end
        end else if (state == HOLD && valid_r && bus.out_ready) begin
            valid_r <= 1'b0;
            state   <= COLLECT;
        end
    end

    assign bus.in_ready  = (state == COLLECT);
    assign bus.out_valid = valid_r;
    assign bus.out_value = value;
endmodule

// File: tb/tb_otf_sd2tc_conv.sv
// tb/tb_otf_sd2tc_conv.sv - self-checking bench for otf_sd2tc_conv (radix 2 x4 and radix 4 x2)
module tb_otf_sd2tc_conv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic       v_valid[2];
    logic       v_abort[2];
    logic       v_ordy[2];
    int         v_digit[2];
    logic       rdy[2];
    logic       ov[2];
    logic       er[2];
    logic [4:0] val[2];

    otf_sd2tc_conv_if #(.RADIX(2), .WIDTH(4)) b2 ();
    otf_sd2tc_conv_if #(.RADIX(4), .WIDTH(2)) b4 ();

    otf_sd2tc_conv #(.RADIX(2), .WIDTH(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
    otf_sd2tc_conv #(.RADIX(4), .WIDTH(2)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

    assign b2.abort     = v_abort[0];
    assign b2.in_valid  = v_valid[0];
    assign b2.in_digit  = v_digit[0][1:0];
    assign b2.out_ready = v_ordy[0];
    assign b4.abort     = v_abort[1];
    assign b4.in_valid  = v_valid[1];
    assign b4.in_digit  = v_digit[1][2:0];
    assign b4.out_ready = v_ordy[1];

    assign rdy[0] = b2.in_ready;
    assign ov[0]  = b2.out_valid;
    assign val[0] = b2.out_value;
    assign er[0]  = b2.digit_err;
    assign rdy[1] = b4.in_ready;
    assign ov[1]  = b4.out_valid;
    assign val[1] = b4.out_value;
    assign er[1]  = b4.digit_err;

    function automatic int rad(int s);
        return (s == 1) ? 4 : 2;
    endfunction

    function automatic int wid(int s);
        return (s == 1) ? 2 : 4;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: collect accepted digits, evaluate sum d_k*RADIX^(WIDTH-1-k)
    int m_dig[2][4];
    int m_cnt[2];
    bit m_hold[2];
    int m_val[2];
    bit m_err[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                m_cnt[s] = 0; m_hold[s] = 0; m_val[s] = 0; m_err[s] = 0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (v_abort[s]) begin
                    m_cnt[s] = 0;
                    m_hold[s] = 0;
                end else if (!m_hold[s] && v_valid[s]) begin
                    int d;
                    d = v_digit[s];
                    if (d == -rad(s)) begin
`ifdef OTF_DIGIT_CHECK_EN
                        m_err[s] = 1;
`endif
                        d = -(rad(s) - 1);
                    end
                    m_dig[s][m_cnt[s]] = d;
                    m_cnt[s]++;
                    if (m_cnt[s] == wid(s)) begin
                        int v;
                        v = 0;
                        for (int k = 0; k < wid(s); k++)
                            v += m_dig[s][k] * (rad(s) ** (wid(s) - 1 - k));
                        m_val[s] = v;
                        m_hold[s] = 1;
                        m_cnt[s] = 0;
                    end
                end else if (m_hold[s] && v_ordy[s]) begin
                    m_hold[s] = 0;
                end
            end
        end
    end

    // Every-cycle comparison of both converters against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int s = 0; s < 2; s++) begin
                chk($sformatf("in_ready[%0d]", s), int'(rdy[s]), int'(!m_hold[s]));
                chk($sformatf("out_valid[%0d]", s), int'(ov[s]), int'(m_hold[s]));
                chk($sformatf("out_value[%0d]", s), int'(val[s]), m_val[s] & 31);
                chk($sformatf("digit_err[%0d]", s), int'(er[s]), int'(m_err[s]));
            end
        end
    end

    task automatic put(int s, int d);
        int t;
        v_valid[s] = 1'b1;
        v_digit[s] = d;
        t = 0;
        while (!rdy[s] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("put_timeout", 0, 1);
        @(negedge clk);
        v_valid[s] = 1'b0;
    endtask

    task automatic take(int s, int exp, string nm, bit lat);
        int t;
        if (lat) chk({nm, "_latency"}, int'(ov[s]), 1);
        t = 0;
        while (!ov[s] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk(nm, int'(val[s]), exp);
        v_ordy[s] = 1'b1;
        @(negedge clk);
        v_ordy[s] = 1'b0;
    endtask

    task automatic send4(int s, int d0, int d1, int d2, int d3);
        put(s, d0); put(s, d1); put(s, d2); put(s, d3);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            v_valid[s] = 0; v_abort[s] = 0; v_ordy[s] = 0; v_digit[s] = 0;
        end
        #12;
        for (int s = 0; s < 2; s++) begin
            chk("reset_in_ready", int'(rdy[s]), 1);
            chk("reset_out_valid", int'(ov[s]), 0);
            chk("reset_out_value", int'(val[s]), 0);
            chk("reset_digit_err", int'(er[s]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        send4(0, 1, 0, -1, 1);
        take(0, 5'b00111, "r2_plus7", 1);
        send4(0, -1, -1, -1, -1);
        take(0, 5'b10001, "r2_minus15", 1);
        send4(0, 1, -1, 1, -1);
        take(0, 5'b00101, "r2_plus5", 1);

        put(1, 3); put(1, -3);
        take(1, 5'b01001, "r4_plus9", 1);
        put(1, -2); put(1, 3);
        take(1, 5'b11011, "r4_minus5", 1);

        // Back-pressure: result held, pending digit must wait
        send4(0, 0, 0, 1, 1);
        v_valid[0] = 1'b1;
        v_digit[0] = 1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", int'(rdy[0]), 0);
            chk("bp_value", int'(val[0]), 5'b00011);
        end
        v_ordy[0] = 1'b1;
        @(negedge clk);
        v_ordy[0] = 1'b0;
        chk("bp_release_ready", int'(rdy[0]), 1);
        @(negedge clk);
        v_valid[0] = 1'b0;
        put(0, 1); put(0, 1); put(0, 1);
        take(0, 5'b01111, "bp_followup", 1);

        // Abort part-way through a number
        put(0, 1); put(0, -1);
        v_abort[0] = 1'b1;
        v_valid[0] = 1'b1;
        v_digit[0] = 1;
        @(negedge clk);
        v_abort[0] = 1'b0;
        v_valid[0] = 1'b0;
        send4(0, 0, 0, 0, 1);
        take(0, 5'b00001, "abort_plus1", 1);

        // Asynchronous reset in the middle of a number
        put(0, 1); put(0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", int'(rdy[0]), 1);
        chk("midrst_out_valid", int'(ov[0]), 0);
        chk("midrst_out_value", int'(val[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send4(0, 0, 0, 1, 0);
        take(0, 5'b00010, "midrst_plus2", 1);

`ifdef OTF_DIGIT_CHECK_EN
        put(0, -2);
        chk("digit_err_set", int'(er[0]), 1);
        put(0, 1); put(0, 1); put(0, 1);
        take(0, 5'b11111, "digit_err_minus1", 1);
        send4(0, 1, 1, 0, 0);
        take(0, 5'b01100, "digit_err_sticky_val", 1);
        chk("digit_err_sticky", int'(er[0]), 1);
`endif

        // Randomised numbers on both converters, checked every cycle by the model
        for (int i = 0; i < 1000; i++) begin
            int s;
            s = int'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                put(s, int'($urandom_range(0, 2 * (rad(s) - 1))) - (rad(s) - 1));
                v_abort[s] = 1'b1;
                @(negedge clk);
                v_abort[s] = 1'b0;
            end
            for (int k = 0; k < wid(s); k++) begin
                int d;
                repeat ($urandom_range(0, 1)) @(negedge clk);
                d = int'($urandom_range(0, 2 * (rad(s) - 1))) - (rad(s) - 1);
`ifdef OTF_DIGIT_CHECK_EN
                if ($urandom_range(0, 49) == 0) d = -rad(s);
`endif
                put(s, d);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            take(s, m_val[s] & 31, "rand_value", 0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
